// File: rtl/sram_lite_slave.sv
// sram_lite_slave
//
// AXI-lite-style responder holding a word-organised SRAM. It sits behind the
// LSU and answers its load/store handshakes with fixed, parameterised
// latencies.
//
// Handshake rule, used on all five channels: a transfer happens on a rising
// clk edge where both valid and ready are high. Once valid is raised, the
// payload that goes with it stays stable until that edge.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   araddr/arvalid/arready             read address channel
//   rdata/rresp/rvalid/rready          read data channel; rdata is shifted
//                                      down by araddr[1:0] bytes so that
//                                      lb/lh/lbu/lhu can take lane 0
//   awaddr/awvalid/awready             write address channel
//   wdata/wstrb/wvalid/wready          write data channel, lane-0 aligned
//                                      (wstrb[7:4] ignored)
//   bresp/bvalid/bready                write response channel
//   rresp/bresp: 2'b00 OKAY, 2'b11 DECERR (address outside the window)
//
// Timing: rvalid rises RD_LATENCY cycles after the cycle in which AR is
// accepted. bvalid rises WR_LATENCY cycles after the cycle in which the
// second of AW/W is accepted. Both latencies must be >= 1.

module sram_lite_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LATENCY  = 2,
  parameter int          WR_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam int          CNT_W     = 8;
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Read FSM states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  // Write FSM states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Storage. No reset: contents survive rst.
  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------
  logic [1:0]       rd_state;
  logic [31:0]      ar_addr_q;
  logic [CNT_W-1:0] rd_cnt;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;

  logic             ar_hs;
  logic             rd_sample;
  logic [31:0]      rd_addr;
  logic [31:0]      rd_rel;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_fwd;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shifted;

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------
  logic [1:0]       wr_state;
  logic             aw_got;
  logic             w_got;
  logic [31:0]      aw_addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [CNT_W-1:0] wr_cnt;
  logic [1:0]       bresp_q;

  logic             aw_hs;
  logic             w_hs;
  logic             both_next;
  logic             wr_commit;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic [31:0]      wr_rel;
  logic             wr_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_strb_wide;
  logic [3:0]       wr_eff_strb;
  logic [31:0]      wr_eff_data;
  logic [31:0]      wr_merged;

  logic             unused_bits;

  // ---------------------------------------------------------------------
  // Handshake-facing outputs. Everything is forced quiet while rst is high.
  // ---------------------------------------------------------------------
  assign arready = (rd_state == R_IDLE) & ~rst;
  assign rvalid  = (rd_state == R_RESP) & ~rst;
  assign rdata   = rst ? 32'd0 : rdata_q;
  assign rresp   = rst ? 2'd0  : rresp_q;

  // The got flags stay set through W_WAIT/W_RESP, which keeps both readies
  // low until the B handshake clears them.
  assign awready = ~aw_got & ~rst;
  assign wready  = ~w_got  & ~rst;
  assign bvalid  = (wr_state == W_RESP) & ~rst;
  assign bresp   = rst ? 2'd0 : bresp_q;

  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;

  // ---------------------------------------------------------------------
  // Read address decode and sampling
  // ---------------------------------------------------------------------
  // With RD_LATENCY == 1 the sample happens on the AR handshake edge itself,
  // before ar_addr_q holds the address, so take it straight from the bus.
  assign rd_addr     = (rd_state == R_IDLE) ? araddr : ar_addr_q;
  assign rd_rel      = rd_addr - ADDR_BASE;
  assign rd_in_range = (rd_addr >= ADDR_BASE) && ({1'b0, rd_rel} < WIN_BYTES);
  assign rd_idx      = rd_rel[IDX_W+1:2];

  assign rd_sample = ((rd_state == R_IDLE) && ar_hs && (RD_LATENCY == 1)) ||
                     ((rd_state == R_WAIT) && (rd_cnt == CNT_W'(1)) && !rst);

  // Write-first: a commit to the same word on the sampling edge is visible
  // to the read.
  assign rd_fwd     = wr_commit && wr_in_range && (wr_idx == rd_idx);
  assign rd_word    = rd_fwd ? wr_merged : mem[rd_idx];
  assign rd_shifted = rd_word >> {rd_addr[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      ar_addr_q <= 32'd0;
      rd_cnt    <= '0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_addr_q <= araddr;
            rd_cnt    <= CNT_W'(RD_LATENCY - 1);
            rd_state  <= (RD_LATENCY == 1) ? R_RESP : R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_cnt == CNT_W'(1)) begin
            rd_state <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt - CNT_W'(1);
          end
        end
        R_RESP: begin
          if (rready) begin
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase

      if (rd_sample) begin
        rdata_q <= rd_in_range ? rd_shifted : 32'd0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Write payload selection and decode
  // ---------------------------------------------------------------------
  // A half that is already held comes from its latch; the half completing
  // on this edge comes from the bus (matters for WR_LATENCY == 1).
  assign wr_addr = aw_got ? aw_addr_q : awaddr;
  assign wr_data = w_got  ? wdata_q   : wdata;
  assign wr_strb = w_got  ? wstrb_q   : wstrb[3:0];

  assign wr_rel      = wr_addr - ADDR_BASE;
  assign wr_in_range = (wr_addr >= ADDR_BASE) && ({1'b0, wr_rel} < WIN_BYTES);
  assign wr_idx      = wr_rel[IDX_W+1:2];

  // Lane-0 data moves up to the addressed byte; anything pushed past bit 31
  // falls off.
  assign wr_strb_wide = {4'b0000, wr_strb} << wr_addr[1:0];
  assign wr_eff_strb  = wr_strb_wide[3:0];
  assign wr_eff_data  = wr_data << {wr_addr[1:0], 3'b000};

  always_comb begin
    wr_merged = mem[wr_idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_eff_strb[b]) begin
        wr_merged[8*b +: 8] = wr_eff_data[8*b +: 8];
      end
    end
  end

  assign both_next = (aw_got | aw_hs) & (w_got | w_hs);

  assign wr_commit = !rst &&
                     (((wr_state == W_IDLE) && both_next && (WR_LATENCY == 1)) ||
                      ((wr_state == W_WAIT) && (wr_cnt == CNT_W'(1))));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      wr_cnt    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got    <= 1'b1;
            aw_addr_q <= awaddr;
          end
          if (w_hs) begin
            w_got   <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb[3:0];
          end
          if (both_next) begin
            wr_cnt   <= CNT_W'(WR_LATENCY - 1);
            wr_state <= (WR_LATENCY == 1) ? W_RESP : W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_cnt == CNT_W'(1)) begin
            wr_state <= W_RESP;
          end else begin
            wr_cnt <= wr_cnt - CNT_W'(1);
          end
        end
        W_RESP: begin
          if (bready) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase

      if (wr_commit) begin
        bresp_q <= wr_in_range ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Whole-word write of the merged value; unstrobed bytes keep their old
  // contents. wstrb = 0 therefore leaves the word unchanged.
  always_ff @(posedge clk) begin
    if (wr_commit && wr_in_range) begin
      mem[wr_idx] <= wr_merged;
    end
  end

  assign unused_bits = ^{wstrb[7:4], wr_strb_wide[7:4]};

endmodule

// File: tb/tb_sram_lite_slave.sv
// tb_sram_lite_slave
//
// Directed steps followed by random traffic against sram_lite_slave with its
// default parameters. The reference memory covers words 0..15 of the window
// and applies the byte-lane rules one byte at a time.

module tb_sram_lite_slave;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model [16];

  sram_lite_slave dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic in_win(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_4000);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - 32'h8000_0000) / 4);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] r;
    int off;
    if (!in_win(a)) return 32'd0;
    w = model[word_of(a)];
    off = int'(a % 4);
    r = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (j + off < 4) r[8*j +: 8] = w[8*(j+off) +: 8];
    end
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    int off;
    int idx;
    if (!in_win(a)) return;
    off = int'(a % 4);
    idx = word_of(a);
    for (int k = 0; k < 4; k++) begin
      if (k - off >= 0 && s[k-off]) model[idx][8*k +: 8] = d[8*(k-off) +: 8];
    end
  endtask

  // ---------------- drivers (called at a negedge, return at a negedge) ----
  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic [1:0] r, output int lat);
    int t;
    t = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    check("ar_accept", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    d = rdata; r = rresp;
    @(negedge clk);
    check("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                    input int da, input int dw, output logic [1:0] b, output int lat);
    int c;
    bit ad;
    bit wd;
    c = 0; ad = 0; wd = 0;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    while (!(ad && wd) && c < 40) begin
      awvalid = !ad && (c >= da);
      wvalid  = !wd && (c >= dw);
      if (ad) check("awready_low_after_aw", 32'(awready), 32'd0);
      if (wd) check("wready_low_after_w", 32'(wready), 32'd0);
      if (awvalid && awready) ad = 1;
      if (wvalid && wready) wd = 1;
      @(negedge clk);
      c++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_w_accept", {30'd0, ad, wd}, 32'd3);
    lat = 1;
    while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
    b = bresp;
    @(negedge clk);
    check("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] held;
    logic [7:0]  s;
    logic [1:0]  r;
    int          lat;

    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resps", {28'd0, rresp, bresp}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_readies", {29'd0, arready, awready, wready}, 32'd7);
    @(negedge clk);

    // Preload words 0..15 so every later read has a known expectation
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      wr(32'h8000_0000 + 32'(4 * i), wd, 8'h0F, 0, 0, r, lat);
      model_write(32'h8000_0000 + 32'(4 * i), wd, 8'h0F);
    end

    // 1: AW and W in the same cycle, then read back
    wr(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, r, lat);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F);
    check("t1_bresp", 32'(r), 32'd0);
    check("t1_b_latency", 32'(lat), 32'(WR_LAT));
    rd(32'h8000_0010, d, r, lat);
    check("t1_rdata", d, 32'hDEAD_BEEF);
    check("t1_rresp", 32'(r), 32'd0);
    check("t1_r_latency", 32'(lat), 32'(RD_LAT));

    // 2: W three cycles ahead of AW, single byte at offset 3
    wr(32'h8000_0013, 32'h0000_0055, 8'h01, 3, 0, r, lat);
    model_write(32'h8000_0013, 32'h0000_0055, 8'h01);
    check("t2_bresp", 32'(r), 32'd0);
    check("t2_b_latency", 32'(lat), 32'(WR_LAT));
    rd(32'h8000_0010, d, r, lat);
    check("t2_word", d, 32'h55AD_BEEF);
    rd(32'h8000_0012, d, r, lat);
    check("t2_half_at_2", d, 32'h0000_55AD);

    // 3a: read with rready held low for 5 cycles
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b0;
    check("t3_arready_start", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t3_rvalid_held", 32'(rvalid), 32'd1);
      check("t3_rdata_held", rdata, 32'h55AD_BEEF);
      check("t3_rresp_held", 32'(rresp), 32'd0);
      check("t3_arready_low", 32'(arready), 32'd0);
      @(negedge clk);
    end
    check("t3_rvalid_before_ready", 32'(rvalid), 32'd1);
    rready = 1'b1;
    @(negedge clk);
    check("t3_rvalid_after_hs", 32'(rvalid), 32'd0);
    check("t3_arready_after_hs", 32'(arready), 32'd1);

    // 3b: write with bready held low for 4 cycles
    wd = $urandom;
    awaddr = 32'h8000_0014; wdata = wd; wstrb = 8'h0F;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("t3_aw_w_low_wait", {30'd0, awready, wready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("t3_bvalid_held", 32'(bvalid), 32'd1);
      check("t3_bresp_held", 32'(bresp), 32'd0);
      check("t3_aw_w_low_resp", {30'd0, awready, wready}, 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    check("t3_bvalid_after_hs", 32'(bvalid), 32'd0);
    check("t3_aw_w_ready_after_hs", {30'd0, awready, wready}, 32'd3);
    model_write(32'h8000_0014, wd, 8'h0F);
    rd(32'h8000_0014, d, r, lat);
    check("t3_write_landed", d, exp_read(32'h8000_0014));

    // 4: out-of-range read and write
    rd(32'h7FFF_FFFC, d, r, lat);
    check("t4_rdata", d, 32'd0);
    check("t4_rresp", 32'(r), 32'd3);
    wr(32'h8000_4000, 32'hFFFF_FFFF, 8'h0F, 0, 1, r, lat);
    check("t4_bresp", 32'(r), 32'd3);
    rd(32'h8000_0000, d, r, lat);
    check("t4_word0_unchanged", d, model[0]);

    // 5: read sample and write commit to the same word on the same edge
    araddr = 32'h8000_0020; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h8000_0020; awvalid = 1'b1;
    wdata = 32'h1234_5678; wstrb = 8'h0F; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t5_rvalid", 32'(rvalid), 32'd1);
    check("t5_bvalid", 32'(bvalid), 32'd1);
    check("t5_rdata_write_first", rdata, 32'h1234_5678);
    @(negedge clk);
    model_write(32'h8000_0020, 32'h1234_5678, 8'h0F);

    // 6: reset while both FSMs are waiting
    held = model[12];
    araddr = 32'h8000_0030; arvalid = 1'b1;
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    wdata = ~held; wstrb = 8'h0F; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_valids_in_rst", {30'd0, rvalid, bvalid}, 32'd0);
    check("t6_readies_in_rst", {29'd0, arready, awready, wready}, 32'd0);
    check("t6_rdata_in_rst", rdata, 32'd0);
    rst = 1'b0;
    #1;
    check("t6_readies_after_rst", {29'd0, arready, awready, wready}, 32'd7);
    @(negedge clk);
    check("t6_no_stale_valids", {30'd0, rvalid, bvalid}, 32'd0);
    rd(32'h8000_0030, d, r, lat);
    check("t6_write_discarded", d, held);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) == 1) ? 32'h8000_4000 + 32'($urandom_range(0, 255))
                                        : 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
      end else begin
        a = 32'h8000_0000 + 32'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        s  = 8'($urandom_range(0, 255));
        wr(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
        check("rnd_bresp", 32'(r), in_win(a) ? 32'd0 : 32'd3);
        check("rnd_b_latency", 32'(lat), 32'(WR_LAT));
        model_write(a, wd, s);
      end else begin
        rd(a, d, r, lat);
        check("rnd_rdata", d, exp_read(a));
        check("rnd_rresp", 32'(r), in_win(a) ? 32'd0 : 32'd3);
        check("rnd_r_latency", 32'(lat), 32'(RD_LAT));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
